cfg_bus_master: RTL and testbench

Initiator for the 14-bit-address / 32-bit-data configuration register bus. It accepts single-beat read/write commands from a host-side valid/ready channel and drives the register-bus strobes, honouring `reg_wait_request`. It captures read data on `reg_rd_data_vld` and returns exactly one response per command, with optional timeout error reporting. It sits between the host interface logic and the configuration mux that decodes `reg_addr[13:12]`.

---
 rtl/cfg_bus_pkg.sv | 17 +
 rtl/cfg_bus_timeout_cnt.sv | 29 ++
 rtl/cfg_bus_master.sv | 142 ++++++++++++++
 tb/tb_cfg_bus_master.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_bus_pkg.sv
// Shared types and constants for the configuration register bus master.
package cfg_bus_pkg;

    localparam int unsigned CFG_ADDR_W      = 14;
    localparam int unsigned CFG_DATA_W      = 32;
    localparam int unsigned CFG_TIMEOUT_CYC = 255;
    localparam logic [31:0] CFG_ERR_DATA    = 32'hDEAD_DEAD;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        RD      = 3'd2,
        RD_WAIT = 3'd3,
        RSP     = 3'd4
    } cfg_state_t;

endpackage

// File: rtl/cfg_bus_timeout_cnt.sv
// Per-access cycle counter; expired flags the last cycle an access may occupy the bus.
module cfg_bus_timeout_cnt
    import cfg_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = CFG_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC + 1 > 256) ? $clog2(TIMEOUT_CYC + 1) : 8;

    logic [CNT_W-1:0] count;

    // Saturates so a long RD_WAIT tail can never wrap back below the limit.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count <= '0;
        end else if (enable && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count >= CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/cfg_bus_master.sv
// Single-outstanding initiator for the config register bus.
// Optional access timeout enabled by defining CFG_BUS_MASTER_TIMEOUT_EN.
module cfg_bus_master
    import cfg_bus_pkg::*;
#(
    parameter int unsigned ADDR_W      = CFG_ADDR_W,
    parameter int unsigned DATA_W      = CFG_DATA_W,
    parameter int unsigned TIMEOUT_CYC = CFG_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [3:0]        cmd_be,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              reg_wr_en,
    output logic              reg_rd_en,
    output logic [3:0]        reg_byte_enable,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wr_data,
    input  logic [DATA_W-1:0] reg_rd_data,
    input  logic              reg_rd_data_vld,
    input  logic              reg_wait_request
);

    cfg_state_t state;
    logic       expired;
    logic       err_q;

    assign cmd_ready = (state == IDLE) && rst_n;
    assign rsp_err   = err_q;

`ifdef CFG_BUS_MASTER_TIMEOUT_EN
    logic cnt_clear;
    logic cnt_enable;

    assign cnt_clear  = cmd_valid && cmd_ready && !(cmd_write && (cmd_be == 4'h0));
    assign cnt_enable = (state == WR) || (state == RD) || (state == RD_WAIT);

    cfg_bus_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (cnt_clear),
        .enable  (cnt_enable),
        .expired (expired)
    );
`else
    assign expired = 1'b0;
`endif

    // A normal accept or data return always wins over a timeout in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            reg_wr_en       <= 1'b0;
            reg_rd_en       <= 1'b0;
            reg_byte_enable <= 4'h0;
            reg_addr        <= '0;
            reg_wr_data     <= '0;
            rsp_valid       <= 1'b0;
            rsp_rdata       <= '0;
            err_q           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        rsp_rdata <= '0;
                        err_q     <= 1'b0;
                        if (cmd_write && (cmd_be == 4'h0)) begin
                            rsp_valid <= 1'b1;
                            state     <= RSP;
                        end else if (cmd_write) begin
                            reg_addr        <= cmd_addr;
                            reg_wr_data     <= cmd_wdata;
                            reg_byte_enable <= cmd_be;
                            reg_wr_en       <= 1'b1;
                            state           <= WR;
                        end else begin
                            reg_addr        <= cmd_addr;
                            reg_wr_data     <= '0;
                            reg_byte_enable <= 4'hF;
                            reg_rd_en       <= 1'b1;
                            state           <= RD;
                        end
                    end
                end
                WR: begin
                    if (!reg_wait_request) begin
                        reg_wr_en <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RSP;
                    end else if (expired) begin
                        reg_wr_en <= 1'b0;
                        rsp_valid <= 1'b1;
                        err_q     <= 1'b1;
                        state     <= RSP;
                    end
                end
                RD: begin
                    if (!reg_wait_request) begin
                        reg_rd_en <= 1'b0;
                        state     <= RD_WAIT;
                    end else if (expired) begin
                        reg_rd_en <= 1'b0;
                        rsp_rdata <= DATA_W'(CFG_ERR_DATA);
                        rsp_valid <= 1'b1;
                        err_q     <= 1'b1;
                        state     <= RSP;
                    end
                end
                RD_WAIT: begin
                    if (reg_rd_data_vld) begin
                        rsp_rdata <= reg_rd_data;
                        rsp_valid <= 1'b1;
                        state     <= RSP;
                    end else if (expired) begin
                        rsp_rdata <= DATA_W'(CFG_ERR_DATA);
                        rsp_valid <= 1'b1;
                        err_q     <= 1'b1;
                        state     <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_bus_master.sv
// Directed bench for cfg_bus_master with a transaction-level expectation model.
// Timeout scenario is compiled in when CFG_BUS_MASTER_TIMEOUT_EN is defined.
module tb_cfg_bus_master;
    import cfg_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [13:0] cmd_addr = '0;
    logic [3:0]  cmd_be = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        reg_wr_en;
    logic        reg_rd_en;
    logic [3:0]  reg_byte_enable;
    logic [13:0] reg_addr;
    logic [31:0] reg_wr_data;
    logic [31:0] reg_rd_data = '0;
    logic        reg_rd_data_vld = 1'b0;
    logic        reg_wait_request = 1'b0;

    cfg_bus_master #(
        .ADDR_W      (14),
        .DATA_W      (32),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_write        (cmd_write),
        .cmd_addr         (cmd_addr),
        .cmd_be           (cmd_be),
        .cmd_wdata        (cmd_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_rdata        (rsp_rdata),
        .rsp_err          (rsp_err),
        .reg_wr_en        (reg_wr_en),
        .reg_rd_en        (reg_rd_en),
        .reg_byte_enable  (reg_byte_enable),
        .reg_addr         (reg_addr),
        .reg_wr_data      (reg_wr_data),
        .reg_rd_data      (reg_rd_data),
        .reg_rd_data_vld  (reg_rd_data_vld),
        .reg_wait_request (reg_wait_request)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        write;
        logic [13:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } acc_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    acc_t acc_q[$];
    rsp_t rsp_q[$];

    int n_checks = 0;
    int n_fail = 0;

    int          cyc = 0;
    int          acc_cyc, rsp_cyc, strobe_cyc, acc_events, rsp_vcyc;
    bit          rsp_done;
    logic [31:0] last_rdata;
    int          stall_left = 0;
    int          hold_left = 0;
    int          resp_lat = 1;
    int          rd_countdown = 0;
    logic [31:0] resp_data = '0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Compare process: every active cycle, bus strobes and responses must match the model queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (reg_wr_en || reg_rd_en) begin
                if (acc_q.size() == 0) begin
                    check_output("unexpected_strobe", 32'd1, 32'd0);
                end else begin
                    check_output("strobe_kind", {30'd0, reg_wr_en, reg_rd_en},
                                 acc_q[0].write ? 32'd2 : 32'd1);
                    check_output("strobe_addr", {18'd0, reg_addr}, {18'd0, acc_q[0].addr});
                    check_output("strobe_be", {28'd0, reg_byte_enable},
                                 acc_q[0].write ? {28'd0, acc_q[0].be} : 32'hF);
                    if (acc_q[0].write)
                        check_output("strobe_wdata", reg_wr_data, acc_q[0].wdata);
                    if (!reg_wait_request)
                        void'(acc_q.pop_front());
                end
            end
            if (rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    check_output("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    check_output("rsp_rdata", rsp_rdata, rsp_q[0].rdata);
                    check_output("rsp_err", {31'd0, rsp_err}, {31'd0, rsp_q[0].err});
                    if (rsp_ready)
                        void'(rsp_q.pop_front());
                end
            end
            check_output("ready_exclusive",
                         {31'd0, cmd_ready && (reg_wr_en || reg_rd_en || rsp_valid)}, 32'd0);
        end
    end

    // One clock of bench time: gather statistics, then act as responder and host after the edge.
    task automatic tick();
        bit rd_acc;
        @(negedge clk);
        if (cmd_valid && cmd_ready) acc_cyc = cyc;
        if (reg_wr_en || reg_rd_en) strobe_cyc++;
        if ((reg_wr_en || reg_rd_en) && !reg_wait_request) acc_events++;
        if (rsp_valid) begin
            rsp_vcyc++;
            if (rsp_cyc < 0) rsp_cyc = cyc;
            if (rsp_ready) begin
                rsp_done = 1'b1;
                last_rdata = rsp_rdata;
            end
        end
        rd_acc = reg_rd_en && !reg_wait_request && rst_n;
        @(posedge clk);
        cyc++;
        #1;
        reg_rd_data_vld = 1'b0;
        if (rd_acc && resp_lat > 0) rd_countdown = resp_lat;
        if (rd_countdown > 0) begin
            rd_countdown--;
            if (rd_countdown == 0) begin
                reg_rd_data_vld = 1'b1;
                reg_rd_data = resp_data;
            end
        end
        if ((reg_wr_en || reg_rd_en) && stall_left > 0) begin
            reg_wait_request = 1'b1;
            stall_left--;
        end else begin
            reg_wait_request = 1'b0;
        end
        if (rsp_valid && hold_left > 0) begin
            rsp_ready = 1'b0;
            hold_left--;
        end else begin
            rsp_ready = 1'b1;
        end
    endtask

    task automatic apply_stimulus(input logic write, input logic [13:0] addr, input logic [3:0] be,
                                  input logic [31:0] wdata, input logic [31:0] rdata,
                                  input logic exp_err);
        int   n;
        acc_t a;
        rsp_t r;
        strobe_cyc = 0;
        acc_events = 0;
        rsp_vcyc   = 0;
        rsp_cyc    = -1;
        acc_cyc    = -1;
        rsp_done   = 1'b0;
        resp_data  = rdata;
        n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        if (!cmd_ready) check_output("cmd_ready_wait", 32'd0, 32'd1);
        cmd_valid = 1'b1;
        cmd_write = write;
        cmd_addr  = addr;
        cmd_be    = be;
        cmd_wdata = wdata;
        if (!(write && be == 4'h0)) begin
            a.write = write;
            a.addr  = addr;
            a.be    = be;
            a.wdata = wdata;
            acc_q.push_back(a);
        end
        r.err   = exp_err;
        r.rdata = write ? 32'h0 : (exp_err ? CFG_ERR_DATA : rdata);
        rsp_q.push_back(r);
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_done && n < 100) begin
            tick();
            n++;
        end
        if (!rsp_done) check_output("rsp_wait", 32'd0, 32'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin : stimulus
        int prev_acc;

        repeat (3) tick();
        check_output("reset_wr_en", {31'd0, reg_wr_en}, 32'd0);
        check_output("reset_rd_en", {31'd0, reg_rd_en}, 32'd0);
        check_output("reset_be", {28'd0, reg_byte_enable}, 32'd0);
        check_output("reset_addr", {18'd0, reg_addr}, 32'd0);
        check_output("reset_wdata", reg_wr_data, 32'd0);
        check_output("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_output("reset_rdata", rsp_rdata, 32'd0);
        check_output("reset_err", {31'd0, rsp_err}, 32'd0);
        check_output("reset_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        rst_n = 1'b1;
        #1;
        check_output("release_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        $display("[TB] single write, no stall");
        apply_stimulus(1'b1, 14'h0010, 4'hF, 32'h1234_5678, 32'h0, 1'b0);
        check_output("wr_strobe_cycles", strobe_cyc, 32'd1);
        check_output("wr_rsp_latency", rsp_cyc - acc_cyc, 32'd2);
        prev_acc = acc_cyc;
        apply_stimulus(1'b1, 14'h0011, 4'h3, 32'hA5A5_0F0F, 32'h0, 1'b0);
        check_output("wr_period", acc_cyc - prev_acc, 32'd3);

        $display("[TB] single read, data one cycle after strobe");
        resp_lat = 1;
        apply_stimulus(1'b0, 14'h0004, 4'h0, 32'h0, 32'hCAFE_0001, 1'b0);
        check_output("rd_strobe_cycles", strobe_cyc, 32'd1);
        check_output("rd_rsp_latency", rsp_cyc - acc_cyc, 32'd3);
        check_output("rd_data_literal", last_rdata, 32'hCAFE_0001);
        prev_acc = acc_cyc;
        apply_stimulus(1'b0, 14'h2FFC, 4'h0, 32'h0, 32'h0000_BEEF, 1'b0);
        check_output("rd_period", acc_cyc - prev_acc, 32'd4);

        $display("[TB] write stalled five cycles");
        stall_left = 5;
        apply_stimulus(1'b1, 14'h1230, 4'h5, 32'hFEED_FACE, 32'h0, 1'b0);
        check_output("stall_strobe_cycles", strobe_cyc, 32'd6);
        check_output("stall_accesses", acc_events, 32'd1);
        check_output("stall_rsp_latency", rsp_cyc - acc_cyc, 32'd7);

        $display("[TB] read response held four cycles");
        hold_left = 4;
        apply_stimulus(1'b0, 14'h3008, 4'h0, 32'h0, 32'h5A5A_0003, 1'b0);
        check_output("hold_rsp_valid_cycles", rsp_vcyc, 32'd5);
        check_output("hold_rdata_literal", last_rdata, 32'h5A5A_0003);

        $display("[TB] write with zero byte enables");
        apply_stimulus(1'b1, 14'h0100, 4'h0, 32'h1111_2222, 32'h0, 1'b0);
        check_output("be0_strobe_cycles", strobe_cyc, 32'd0);
        check_output("be0_rsp_latency", rsp_cyc - acc_cyc, 32'd1);

`ifdef CFG_BUS_MASTER_TIMEOUT_EN
        $display("[TB] read timeout");
        resp_lat = 0;
        apply_stimulus(1'b0, 14'h0040, 4'h0, 32'h0, 32'h0, 1'b1);
        check_output("to_rsp_latency", rsp_cyc - acc_cyc, 32'd9);
        check_output("to_rdata_literal", last_rdata, 32'hDEAD_DEAD);
        reg_rd_data_vld = 1'b1;
        reg_rd_data = 32'hBAD0_BAD0;
        tick();
        check_output("late_vld_ignored", {31'd0, rsp_valid}, 32'd0);
        resp_lat = 1;
        apply_stimulus(1'b0, 14'h0044, 4'h0, 32'h0, 32'hCAFE_0002, 1'b0);
        check_output("after_to_rdata", last_rdata, 32'hCAFE_0002);
`endif

        $display("[TB] reset during read wait");
        resp_lat = 0;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 14'h0ABC;
        acc_q.push_back('{write: 1'b0, addr: 14'h0ABC, be: 4'hF, wdata: 32'h0});
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        acc_q.delete();
        rsp_q.delete();
        rd_countdown = 0;
        tick();
        check_output("rst_rd_en", {31'd0, reg_rd_en}, 32'd0);
        check_output("rst_wr_en", {31'd0, reg_wr_en}, 32'd0);
        check_output("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_output("rst_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
        rst_n = 1'b1;
        #1;
        check_output("rst_cmd_ready_release", {31'd0, cmd_ready}, 32'd1);
        resp_lat = 1;
        apply_stimulus(1'b0, 14'h0ABC, 4'h0, 32'h0, 32'h7777_8888, 1'b0);
        check_output("rst_recover_rdata", last_rdata, 32'h7777_8888);

        tick();
        check_output("acc_queue_drained", acc_q.size(), 32'd0);
        check_output("rsp_queue_drained", rsp_q.size(), 32'd0);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
